// File: rtl/game_result_led_seq.sv
// game_result_led_seq: latches a game-end result (P1 win, P2 win or draw) and blinks
// the matching RGB colour BLINK_COUNT times, then holds it until clear.
// Optional macro RGB_PWM_DIM_EN: dims the HOLD colour with a free-running PWM counter.
module game_result_led_seq #(
  parameter int BLINK_DIV   = 25_000_000,
  parameter int BLINK_COUNT = 3,
  parameter int PWM_BITS    = 4,
  parameter int HOLD_DUTY   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] detect_win,
  input  logic       no_space,
  input  logic       clear,
  output logic [2:0] LED_out,
  output logic       busy,
  output logic       done
);

  // Counter widths. Both are forced to at least one bit so that a zero blink count
  // or a divider of one still elaborates to legal vectors.
  localparam int TMR_W = (BLINK_DIV < 1) ? 1 : $clog2(BLINK_DIV + 1);
  localparam int CNT_W = (BLINK_COUNT < 1) ? 1 : $clog2(BLINK_COUNT + 1);

  // Timer reload gives exactly BLINK_DIV cycles per phase (count down to zero inclusive).
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'((BLINK_DIV < 1) ? 0 : BLINK_DIV - 1);

  // Index of the final blink; unused when the blink phase is skipped entirely.
  localparam logic [CNT_W-1:0] LAST_BLINK = CNT_W'((BLINK_COUNT < 1) ? 0 : BLINK_COUNT - 1);

  localparam bit SKIP_BLINK = (BLINK_COUNT == 0);

  // Colour encoding on {red, green, blue}.
  localparam logic [2:0] COL_OFF  = 3'b000;
  localparam logic [2:0] COL_P1   = 3'b100;
  localparam logic [2:0] COL_P2   = 3'b010;
  localparam logic [2:0] COL_DRAW = 3'b001;

  // Parameter legality is checked at elaboration; nothing here exists in hardware.
  if (BLINK_DIV < 1) begin : g_bad_div
    $error("game_result_led_seq: BLINK_DIV must be >= 1");
  end
  if (BLINK_COUNT < 0) begin : g_bad_count
    $error("game_result_led_seq: BLINK_COUNT must be >= 0");
  end
  if (PWM_BITS < 1 || HOLD_DUTY < 0 || HOLD_DUTY > (2 ** PWM_BITS)) begin : g_bad_pwm
    $error("game_result_led_seq: HOLD_DUTY must fit in a 2**PWM_BITS period");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BLINK_ON  = 2'd1,
    BLINK_OFF = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t           state;
  logic [2:0]       color_q;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] blink_cnt;

  logic             ev_vld;
  logic [2:0]       ev_color;
  logic             pwm_on;

  // Decode the game-end event: a win outranks a full board; 2'b11 is not a win.
  always_comb begin
    ev_vld   = 1'b0;
    ev_color = COL_OFF;
    if (detect_win == 2'b01) begin
      ev_vld   = 1'b1;
      ev_color = COL_P1;
    end else if (detect_win == 2'b10) begin
      ev_vld   = 1'b1;
      ev_color = COL_P2;
    end else if (no_space) begin
      ev_vld   = 1'b1;
      ev_color = COL_DRAW;
    end
  end

`ifdef RGB_PWM_DIM_EN
  localparam logic [PWM_BITS:0] DUTY = (PWM_BITS + 1)'(HOLD_DUTY);

  logic [PWM_BITS-1:0] pwm_cnt;

  // Free-running dimming counter; only reset clears it so the PWM phase is independent of clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  assign pwm_on = ({1'b0, pwm_cnt} < DUTY);
`else
  // Without dimming the hold colour is driven continuously.
  assign pwm_on = 1'b1;
`endif

  // Main sequencer: state, latched colour, counters and all registered outputs move together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      color_q   <= COL_OFF;
      timer     <= '0;
      blink_cnt <= '0;
      LED_out   <= COL_OFF;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (clear) begin
      // clear wins over any event presented in the same cycle.
      state     <= IDLE;
      color_q   <= COL_OFF;
      timer     <= '0;
      blink_cnt <= '0;
      LED_out   <= COL_OFF;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          LED_out <= COL_OFF;
          busy    <= 1'b0;
          done    <= 1'b0;
          if (ev_vld) begin
            color_q   <= ev_color;
            timer     <= TMR_RELOAD;
            blink_cnt <= '0;
            if (SKIP_BLINK) begin
              state   <= HOLD;
              done    <= 1'b1;
              LED_out <= pwm_on ? ev_color : COL_OFF;
            end else begin
              state   <= BLINK_ON;
              busy    <= 1'b1;
              LED_out <= ev_color;
            end
          end
        end

        BLINK_ON: begin
          if (timer == '0) begin
            state   <= BLINK_OFF;
            timer   <= TMR_RELOAD;
            LED_out <= COL_OFF;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        BLINK_OFF: begin
          if (timer == '0) begin
            if (blink_cnt == LAST_BLINK) begin
              state   <= HOLD;
              busy    <= 1'b0;
              done    <= 1'b1;
              LED_out <= pwm_on ? color_q : COL_OFF;
            end else begin
              state     <= BLINK_ON;
              blink_cnt <= blink_cnt + 1'b1;
              timer     <= TMR_RELOAD;
              LED_out   <= color_q;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end

        HOLD: begin
          LED_out <= pwm_on ? color_q : COL_OFF;
        end

        default: begin
          state   <= IDLE;
          LED_out <= COL_OFF;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_result_led_seq.sv
// Directed bench for game_result_led_seq: dut_a blinks twice with a 4-cycle half-period,
// dut_b has a zero blink count and goes straight to hold. Both share the stimulus.
// Hold-phase LED checks switch between steady and dimmed expectations on RGB_PWM_DIM_EN.
module tb_game_result_led_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] detect_win;
  logic       no_space;
  logic       clear;

  logic [2:0] led_a, led_b;
  logic       busy_a, busy_b;
  logic       done_a, done_b;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  game_result_led_seq #(
    .BLINK_DIV  (4),
    .BLINK_COUNT(2),
    .PWM_BITS   (4),
    .HOLD_DUTY  (4)
  ) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .detect_win(detect_win),
    .no_space  (no_space),
    .clear     (clear),
    .LED_out   (led_a),
    .busy      (busy_a),
    .done      (done_a)
  );

  game_result_led_seq #(
    .BLINK_DIV  (4),
    .BLINK_COUNT(0),
    .PWM_BITS   (4),
    .HOLD_DUTY  (4)
  ) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .detect_win(detect_win),
    .no_space  (no_space),
    .clear     (clear),
    .LED_out   (led_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  // One clock edge, then settle 1 time unit so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    vec_cnt++;
    if ({led_a, busy_a, done_a} !== 5'b000_0_0) begin
      err_cnt++;
      $display("FAIL reset_a got led/busy/done=%b/%b/%b want 000/0/0", led_a, busy_a, done_a);
    end
    vec_cnt++;
    if ({led_b, busy_b, done_b} !== 5'b000_0_0) begin
      err_cnt++;
      $display("FAIL reset_b got led/busy/done=%b/%b/%b want 000/0/0", led_b, busy_b, done_b);
    end
  endtask

  // Full P1 timeline: event at edge 0, cycles 1..20 checked.
  task automatic test_p1_blink();
    logic [2:0] exp_led;
    logic [2:0] mask;
    logic       exp_busy, exp_done;
    detect_win = 2'b01;
    tick();
    detect_win = 2'b00;
    vec_cnt++;
    if (done_b !== 1'b1 || busy_b !== 1'b0) begin
      err_cnt++;
      $display("FAIL p1_zero_count_b got busy/done=%b/%b want 0/1", busy_b, done_b);
    end
    for (int k = 1; k <= 20; k++) begin
      if (k > 16) begin
        exp_led = 3'b100; exp_busy = 1'b0; exp_done = 1'b1;
`ifdef RGB_PWM_DIM_EN
        mask = 3'b000;
`else
        mask = 3'b111;
`endif
      end else begin
        exp_led  = (((k - 1) / 4) % 2 == 0) ? 3'b100 : 3'b000;
        exp_busy = 1'b1; exp_done = 1'b0; mask = 3'b111;
      end
      vec_cnt++;
      if ({led_a & mask, busy_a, done_a} !== {exp_led & mask, exp_busy, exp_done}) begin
        err_cnt++;
        $display("FAIL p1_blink cycle %0d got led/busy/done=%b/%b/%b want %b/%b/%b",
                 k, led_a, busy_a, done_a, exp_led, exp_busy, exp_done);
      end
      tick();
    end
    pulse_clear();
    vec_cnt++;
    if ({led_a, busy_a, done_a} !== 5'b000_0_0) begin
      err_cnt++;
      $display("FAIL p1_clear got led/busy/done=%b/%b/%b want 000/0/0", led_a, busy_a, done_a);
    end
  endtask

  task automatic test_priority();
    pulse_clear();
    detect_win = 2'b10; no_space = 1'b1;
    tick();
    detect_win = 2'b00; no_space = 1'b0;
    vec_cnt++;
    if ({led_a, busy_a} !== 4'b010_1) begin
      err_cnt++;
      $display("FAIL prio_win_over_full got led/busy=%b/%b want 010/1", led_a, busy_a);
    end
    pulse_clear();
    no_space = 1'b1;
    tick();
    no_space = 1'b0;
    vec_cnt++;
    if ({led_a, busy_a} !== 4'b001_1) begin
      err_cnt++;
      $display("FAIL prio_draw got led/busy=%b/%b want 001/1", led_a, busy_a);
    end
    pulse_clear();
    detect_win = 2'b11;
    tick();
    tick();
    detect_win = 2'b00;
    vec_cnt++;
    if ({led_a, busy_a, done_a, done_b} !== 6'b000_0_0_0) begin
      err_cnt++;
      $display("FAIL prio_win11_ignored got led_a/busy_a/done_a/done_b=%b/%b/%b/%b want 000/0/0/0",
               led_a, busy_a, done_a, done_b);
    end
    clear = 1'b1; detect_win = 2'b01;
    tick();
    clear = 1'b0; detect_win = 2'b00;
    vec_cnt++;
    if ({led_a, busy_a, done_b} !== 5'b000_0_0) begin
      err_cnt++;
      $display("FAIL prio_clear_beats_event got led_a/busy_a/done_b=%b/%b/%b want 000/0/0",
               led_a, busy_a, done_b);
    end
    tick();
    vec_cnt++;
    if ({led_a, busy_a} !== 4'b000_0) begin
      err_cnt++;
      $display("FAIL prio_event_not_retained got led/busy=%b/%b want 000/0", led_a, busy_a);
    end
  endtask

  task automatic test_ignore_and_clear();
    logic [2:0] exp_led;
    pulse_clear();
    detect_win = 2'b01;
    tick();
    detect_win = 2'b10;
    tick();
    detect_win = 2'b00;
    vec_cnt++;
    if ({led_a, busy_a} !== 4'b100_1) begin
      err_cnt++;
      $display("FAIL ignore_in_blink got led/busy=%b/%b want 100/1", led_a, busy_a);
    end
    tick();
    pulse_clear();
    vec_cnt++;
    if ({led_a, busy_a, done_a} !== 5'b000_0_0) begin
      err_cnt++;
      $display("FAIL clear_mid_blink got led/busy/done=%b/%b/%b want 000/0/0", led_a, busy_a, done_a);
    end
    tick();
    tick();
    no_space = 1'b1;
    tick();
    no_space = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      exp_led = (k <= 4) ? 3'b001 : 3'b000;
      vec_cnt++;
      if ({led_a, busy_a} !== {exp_led, 1'b1}) begin
        err_cnt++;
        $display("FAIL draw_after_clear cycle %0d got led/busy=%b/%b want %b/1", k, led_a, busy_a, exp_led);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_blink();
    logic [2:0] exp_led;
    logic [2:0] mask;
    pulse_clear();
    detect_win = 2'b01;
    tick();
    detect_win = 2'b00;
    for (int i = 0; i < 5; i++) tick();
    vec_cnt++;
    if ({led_a, busy_a} !== 4'b000_1) begin
      err_cnt++;
      $display("FAIL reset_mid_in_off got led/busy=%b/%b want 000/1", led_a, busy_a);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vec_cnt++;
    if ({led_a, busy_a, done_a, led_b, busy_b, done_b} !== 10'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_outputs got a=%b/%b/%b b=%b/%b/%b want all 0",
               led_a, busy_a, done_a, led_b, busy_b, done_b);
    end
    tick();
    no_space = 1'b1;
    tick();
    no_space = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      mask = 3'b111;
      if (k > 16) begin
        exp_led = 3'b001;
`ifdef RGB_PWM_DIM_EN
        mask = 3'b000;
`endif
      end else begin
        exp_led = (((k - 1) / 4) % 2 == 0) ? 3'b001 : 3'b000;
      end
      vec_cnt++;
      if ({led_a & mask, busy_a, done_a} !== {exp_led & mask, (k <= 16), (k > 16)}) begin
        err_cnt++;
        $display("FAIL fresh_after_reset cycle %0d got led/busy/done=%b/%b/%b want %b/%b/%b",
                 k, led_a, busy_a, done_a, exp_led, (k <= 16), (k > 16));
      end
      tick();
    end
  endtask

  task automatic test_zero_count_hold();
    int on_cnt;
    pulse_clear();
    detect_win = 2'b10;
    tick();
    detect_win = 2'b00;
    vec_cnt++;
    if ({busy_b, done_b} !== 2'b01) begin
      err_cnt++;
      $display("FAIL zero_count_direct got busy/done=%b/%b want 0/1", busy_b, done_b);
    end
`ifdef RGB_PWM_DIM_EN
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (led_b == 3'b010) on_cnt++;
      else if (led_b !== 3'b000) on_cnt = on_cnt + 100;
      tick();
    end
    vec_cnt++;
    if (on_cnt != 4) begin
      err_cnt++;
      $display("FAIL pwm_hold_duty got %0d colour cycles of 16 want 4", on_cnt);
    end
`else
    vec_cnt++;
    if (led_b !== 3'b010) begin
      err_cnt++;
      $display("FAIL zero_count_colour got led=%b want 010", led_b);
    end
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      if (led_b == 3'b010 && done_b == 1'b1) on_cnt++;
      tick();
    end
    vec_cnt++;
    if (on_cnt != 16) begin
      err_cnt++;
      $display("FAIL steady_hold got %0d colour cycles of 16 want 16", on_cnt);
    end
`endif
    pulse_clear();
    vec_cnt++;
    if ({led_b, done_b} !== 4'b000_0) begin
      err_cnt++;
      $display("FAIL zero_count_clear got led/done=%b/%b want 000/0", led_b, done_b);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    detect_win = 2'b00;
    no_space   = 1'b0;
    clear      = 1'b0;
    tick();
    tick();
    test_reset();
    rst_n = 1'b1;
    tick();
    test_p1_blink();
    test_priority();
    test_ignore_and_clear();
    test_reset_mid_blink();
    test_zero_count_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/game_result_led_seq.md
# game_result_led_seq

Sequencer that owns the board's RGB status LED and plays a game-end indication. When the game logic reports a win or a full board, the block latches the result and blinks the matching colour a fixed number of times. It then holds the colour steady until the top level clears it for a new game. It sits between the win-detection/board-occupancy logic and the LED pins.

## Interface
- `BLINK_DIV`, default 25_000_000: clock cycles per blink half-period (on or off); must be ≥1.
- `BLINK_COUNT`, default 3: number of full on/off blinks before hold; 0 means go straight to hold.
- `PWM_BITS`, default 4: width of the hold-dimming counter (used only with the macro).
- `HOLD_DUTY`, default 4: on-cycles per 2^`PWM_BITS` PWM period in hold (used only with the macro).

Ports:
- `clk`, input, 1: single system clock. All logic is on its rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `detect_win`, input, 2: 01 = player 1 wins, 10 = player 2 wins, 00/11 = no win.
- `no_space`, input, 1: board full.
- `clear`, input, 1: new game; returns the block to idle.
- `LED_out`, output, 3: {red, green, blue}, registered.
- `busy`, output, 1: high in BLINK_ON/BLINK_OFF.
- `done`, output, 1: high in HOLD.

## Operation
- Colour encoding: P1 = 3'b100, P2 = 3'b010, draw = 3'b001, off = 3'b000.
- Event detection, sampled in IDLE only:
  - `detect_win`==01 → P1; `detect_win`==10 → P2.
  - Else `no_space`==1 → draw.
  - Win has priority over `no_space` (a winning final move is a win).
  - `detect_win`==11 is ignored; it is treated as no win.
- On an event the colour is latched into `color_q`. Inputs are ignored in every state except IDLE.
- States:
  - **IDLE**: `LED_out`=000. On event → BLINK_ON, or → HOLD if `BLINK_COUNT`==0. On entry the timer is loaded with `BLINK_DIV`-1 and `blink_cnt` with 0.
  - **BLINK_ON**: `LED_out`=`color_q`. At timer==0 → BLINK_OFF and the timer reloads; otherwise the timer decrements.
  - **BLINK_OFF**: `LED_out`=000. At timer==0:
    - if `blink_cnt`==`BLINK_COUNT`-1 → HOLD;
    - else `blink_cnt`++, timer reloads, → BLINK_ON.
  - **HOLD**: `LED_out`=`color_q` (see Configuration). The block stays here until `clear`.
- `clear`==1 in any state → IDLE on the next edge, with `color_q`, timer and `blink_cnt` zeroed. `clear` beats a same-cycle event; an event is accepted no earlier than the cycle after `clear` falls.
- Widths:
  - timer is $clog2(`BLINK_DIV`+1) bits;
  - `blink_cnt` is $clog2(`BLINK_COUNT`+1) bits;
  - all counters are unsigned down/up counters with no wrap in legal operation.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `LED_out`=000, `busy`=0, `done`=0, `color_q`=000, counters 0. Reset mid-blink aborts the blink immediately.
- `LED_out`, `busy` and `done` are registered and change on the same edge as the state.
- Event sampled at edge N → `LED_out`=colour and `busy`=1 from edge N.
- Each blink phase lasts exactly `BLINK_DIV` cycles. Total blink time is 2·`BLINK_DIV`·`BLINK_COUNT` cycles, then HOLD.
- `clear` at edge M → `LED_out`=000, `done`=0 from edge M.

## Configuration
- `RGB_PWM_DIM_EN` defined:
  - A free-running `PWM_BITS` counter runs from reset.
  - In HOLD, `LED_out`=`color_q` when counter < `HOLD_DUTY`, else 000.
  - Blink phases stay at full brightness.
- `RGB_PWM_DIM_EN` undefined: no PWM counter; HOLD drives `color_q` continuously.

## Test plan
- `BLINK_DIV`=4, `BLINK_COUNT`=2; `detect_win`=01 for one cycle at edge 0 → `LED_out` is:
  - 100 during cycles 1–4;
  - 000 during cycles 5–8;
  - 100 during cycles 9–12;
  - 000 during cycles 13–16;
  - 100 with `done`=1 from cycle 17 onward; `busy`=1 in cycles 1–16.
- `detect_win`=10 together with `no_space`=1 → colour 010 (win priority). `no_space` alone → 001. `detect_win`=11 alone → stays IDLE, `LED_out`=000.
- During BLINK_ON, drive `detect_win`=10 → no change. Then drive `clear` → next edge `LED_out`=000, IDLE. A new `no_space` event two cycles later → blinks 001.
- `rst_n`=0 in the middle of BLINK_OFF → next edge all outputs 0. An event after reset starts a fresh, full-length sequence.
- `BLINK_COUNT`=0 → event goes directly to HOLD; `done`=1 and `LED_out`=colour on the next edge.
- With `RGB_PWM_DIM_EN`, `PWM_BITS`=4, `HOLD_DUTY`=4 → in HOLD `LED_out` is the colour for 4 of every 16 cycles. Without the macro → steady colour.
